// File: rtl/train_sensor_emulator_if.sv
// Control and sensor-line bundle between a stimulus master and the train sensor emulator.
// The master requests a pass and configures it; the emulator drives S1..S6 and status.
interface train_sensor_emulator_if #(
   parameter int TW = 19,
   parameter int PW = 8
);
   logic          start;
   logic          direction;
   logic [TW-1:0] gap_ticks;
   logic [PW-1:0] pulse_ticks;
   logic          abort;
   logic          S1;
   logic          S2;
   logic          S3;
   logic          S4;
   logic          S5;
   logic          S6;
   logic          busy;
   logic          done;
   logic [2:0]    pos;

   modport master (
      output start, direction, gap_ticks, pulse_ticks, abort,
      input  S1, S2, S3, S4, S5, S6, busy, done, pos
   );

   modport slave (
      input  start, direction, gap_ticks, pulse_ticks, abort,
      output S1, S2, S3, S4, S5, S6, busy, done, pos
   );
endinterface

// File: rtl/train_sensor_emulator.sv
// Emulates one train crossing six track sensors in either direction, with programmable
// pulse width and inter-sensor gap, driving registered sensor lines for the controller.
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// PULSE | current sensor line high, counting P cycles
// GAP   | all lines low between sensors, counting G cycles; pos already advanced
// DONE  | one-cycle done pulse, busy low
module train_sensor_emulator #(
   parameter int TW = 19,
   parameter int PW = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   train_sensor_emulator_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] cnt, cnt_nxt;
   logic [2:0]    cur, cur_nxt;
   logic          dir_q, dir_nxt;
   logic [TW-1:0] gap_q, gap_nxt;
   logic [PW-1:0] pm1_q, pm1_nxt;
   logic [PW-1:0] pm1_in;

   logic [5:0]    s_q, s_nxt;
   logic          busy_q, busy_nxt;
   logic          done_q, done_nxt;
   logic [2:0]    pos_q, pos_nxt;

   logic          is_last;
   logic [2:0]    cur_adv;

   // pulse_ticks of 0 behaves as 1, so the stored reload value is max(P,1)-1
   assign pm1_in  = (bus.pulse_ticks == '0) ? '0 : bus.pulse_ticks - PW'(1);
   assign is_last = dir_q ? (cur == 3'd1) : (cur == 3'd6);
   assign cur_adv = dir_q ? (cur - 3'd1) : (cur + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         cur    <= '0;
         dir_q  <= 1'b0;
         gap_q  <= '0;
         pm1_q  <= '0;
         s_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pos_q  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         cur    <= cur_nxt;
         dir_q  <= dir_nxt;
         gap_q  <= gap_nxt;
         pm1_q  <= pm1_nxt;
         s_q    <= s_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         pos_q  <= pos_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_nxt   = cur;
      dir_nxt   = dir_q;
      gap_nxt   = gap_q;
      pm1_nxt   = pm1_q;

      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt = PULSE;
               dir_nxt   = bus.direction;
               gap_nxt   = bus.gap_ticks;
               pm1_nxt   = pm1_in;
               cnt_nxt   = TW'(pm1_in);
               cur_nxt   = bus.direction ? 3'd6 : 3'd1;
            end
         end
         PULSE: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               cur_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - TW'(1);
            end else if (is_last) begin
               state_nxt = DONE;
               cur_nxt   = '0;
            end else begin
               cur_nxt = cur_adv;
               // zero gap chains the next sensor directly, no low cycle in between
               if (gap_q == '0) begin
                  cnt_nxt = TW'(pm1_q);
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = gap_q - TW'(1);
               end
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               cur_nxt   = '0;
            end else if (cnt != '0) begin
               cnt_nxt = cnt - TW'(1);
            end else begin
               state_nxt = PULSE;
               cnt_nxt   = TW'(pm1_q);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            cur_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cur_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they land in flops alongside it
   always_comb begin
      s_nxt    = '0;
      busy_nxt = (state_nxt == PULSE) || (state_nxt == GAP);
      done_nxt = (state_nxt == DONE);
      pos_nxt  = busy_nxt ? cur_nxt : 3'd0;
      if (state_nxt == PULSE) begin
         case (cur_nxt)
            3'd1:    s_nxt = 6'b000001;
            3'd2:    s_nxt = 6'b000010;
            3'd3:    s_nxt = 6'b000100;
            3'd4:    s_nxt = 6'b001000;
            3'd5:    s_nxt = 6'b010000;
            3'd6:    s_nxt = 6'b100000;
            default: s_nxt = 6'b000000;
         endcase
      end
   end

   assign bus.S1   = s_q[0];
   assign bus.S2   = s_q[1];
   assign bus.S3   = s_q[2];
   assign bus.S4   = s_q[3];
   assign bus.S5   = s_q[4];
   assign bus.S6   = s_q[5];
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.pos  = pos_q;

endmodule

// File: tb/tb_train_sensor_emulator.sv
// Self-checking bench for train_sensor_emulator: table-driven pass records, directed
// corner sequences, and randomized passes checked cycle by cycle against a timing model.
module tb_train_sensor_emulator;
   localparam int TW = 19;
   localparam int PW = 8;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   train_sensor_emulator_if #(.TW(TW), .PW(PW)) bus ();

   train_sensor_emulator #(.TW(TW), .PW(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          dir;
      int          pt;
      int          gt;
      int          exp_done;
      logic [17:0] exp_order;
      int          exp_last_rise;
   } rec_t;

   rec_t recs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [5:0] svec();
      return {bus.S6, bus.S5, bus.S4, bus.S3, bus.S2, bus.S1};
   endfunction

   function automatic logic [10:0] observed();
      return {svec(), bus.busy, bus.done, bus.pos};
   endfunction

   function automatic logic [2:0] sensor_no(input int k, input bit dir);
      return dir ? 3'(6 - k) : 3'(k + 1);
   endfunction

   // Expected {S6..S1, busy, done, pos} at cycle t after start was sampled at cycle 0
   function automatic logic [10:0] model(input int t, input bit dir, input int p, input int g);
      int          total;
      int          k;
      int          off;
      logic [5:0]  s;
      logic        b;
      logic        d;
      logic [2:0]  ps;
      total = 6 * p + 5 * g;
      s = '0; b = 1'b0; d = 1'b0; ps = '0;
      if (t >= 1 && t <= total) begin
         k   = (t - 1) / (p + g);
         off = (t - 1) % (p + g);
         b   = 1'b1;
         if (off < p) begin
            ps = sensor_no(k, dir);
            s  = 6'd1 << (ps - 3'd1);
         end else begin
            ps = sensor_no(k + 1, dir);
         end
      end else if (t == total + 1) begin
         d = 1'b1;
      end
      return {s, b, d, ps};
   endfunction

   task automatic drive_cfg(input bit dir, input int pt, input int gt);
      bus.direction   = dir;
      bus.pulse_ticks = PW'(pt);
      bus.gap_ticks   = TW'(gt);
   endtask

   // Runs one pass and compares every cycle with the model; abort_at/restart_at are 0 when unused
   task automatic run_checked(input string nm, input bit dir, input int pt, input int gt,
                              input int abort_at, input int restart_at, input bit noise);
      int p;
      int total;
      int last_t;
      int start_limit;
      logic [10:0] exp;
      p           = (pt == 0) ? 1 : pt;
      total       = 6 * p + 5 * gt;
      last_t      = (abort_at > 0) ? abort_at + 3 : total + 3;
      start_limit = (abort_at > 0) ? abort_at : total + 1;
      drive_cfg(dir, pt, gt);
      bus.abort = 1'b0;
      bus.start = 1'b1;
      for (int t = 1; t <= last_t; t++) begin
         tick();
         exp = (abort_at > 0 && t > abort_at) ? 11'd0 : model(t, dir, p, gt);
         check($sformatf("%s cyc%0d", nm, t), 32'(observed()), 32'(exp));
         bus.start = 1'b0;
         bus.abort = (t == abort_at);
         if (t == restart_at) begin
            bus.start     = 1'b1;
            bus.gap_ticks = TW'(gt + 7);
         end
         if (noise && t <= start_limit) begin
            bus.start       = 1'($urandom_range(0, 1));
            bus.direction   = 1'($urandom_range(0, 1));
            bus.gap_ticks   = TW'($urandom_range(0, 50));
            bus.pulse_ticks = PW'($urandom_range(0, 255));
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic run_record(input bit dir, input int pt, input int gt,
                             output int done_cyc, output logic [17:0] order,
                             output int last_rise, output int multi, output int busy_cyc);
      logic [5:0] s;
      logic [5:0] prev;
      done_cyc = -1; order = '0; last_rise = -1; multi = 0; busy_cyc = 0; prev = '0;
      drive_cfg(dir, pt, gt);
      bus.abort = 1'b0;
      bus.start = 1'b1;
      for (int t = 1; t <= 200; t++) begin
         tick();
         bus.start = 1'b0;
         s = svec();
         if ($countones(s) > 1) multi++;
         if (s != '0 && s != prev) begin
            for (int i = 0; i < 6; i++)
               if (s[i]) order = {order[14:0], 3'(i + 1)};
            last_rise = t;
         end
         if (bus.busy) busy_cyc++;
         prev = s;
         if (bus.done) begin
            done_cyc = t;
            break;
         end
      end
      tick();
   endtask

   initial begin
      int          done_cyc;
      logic [17:0] order;
      int          last_rise;
      int          multi;
      int          busy_cyc;
      int          pt;
      int          gt;
      bit          dir;
      int          ab;

      tests = 0;
      fails = 0;
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      drive_cfg(1'b0, 0, 0);

      recs[0] = '{1'b0, 2, 3, 28, 18'o123456, 26};
      recs[1] = '{1'b1, 1, 0,  7, 18'o654321,  6};
      recs[2] = '{1'b0, 0, 1, 12, 18'o123456, 11};
      recs[3] = '{1'b1, 3, 2, 29, 18'o654321, 26};
      recs[4] = '{1'b0, 1, 0,  7, 18'o123456,  6};
      recs[5] = '{1'b1, 4, 1, 30, 18'o654321, 26};

      #2 rst_n = 1'b0;
      tick();
      tick();
      check("reset outputs", 32'(observed()), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle after reset", 32'(observed()), 32'd0);

      for (int r = 0; r < 6; r++) begin
         run_record(recs[r].dir, recs[r].pt, recs[r].gt, done_cyc, order, last_rise, multi, busy_cyc);
         check($sformatf("rec%0d done cycle", r), 32'(done_cyc), 32'(recs[r].exp_done));
         check($sformatf("rec%0d order", r), 32'(order), 32'(recs[r].exp_order));
         check($sformatf("rec%0d last rise", r), 32'(last_rise), 32'(recs[r].exp_last_rise));
         check($sformatf("rec%0d multi-hot", r), 32'(multi), 32'd0);
         check($sformatf("rec%0d busy cycles", r), 32'(busy_cyc), 32'(recs[r].exp_done - 1));
      end

      run_checked("basic", 1'b0, 2, 3, 0, 0, 1'b0);
      run_checked("restart ignored", 1'b0, 2, 3, 0, 10, 1'b0);
      run_checked("abort", 1'b0, 2, 3, 8, 0, 1'b0);
      run_checked("after abort", 1'b0, 2, 3, 0, 0, 1'b0);
      run_checked("max gap", 1'b1, 1, (1 << TW) - 1, 2000, 0, 1'b0);

      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      check("abort beats start", 32'(observed()), 32'd0);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      check("abort beats start later", 32'(observed()), 32'd0);

      drive_cfg(1'b0, 2, 3);
      bus.start = 1'b1;
      for (int t = 1; t <= 4; t++) begin
         tick();
         bus.start = 1'b0;
      end
      check("mid-gap busy", 32'(observed()), 32'(model(4, 1'b0, 2, 3)));
      #2 rst_n = 1'b0;
      #1;
      check("async reset no edge", 32'(observed()), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle after async reset", 32'(observed()), 32'd0);
      run_checked("pass after reset", 1'b1, 2, 3, 0, 0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         dir = 1'($urandom_range(0, 1));
         pt  = $urandom_range(0, 4);
         gt  = $urandom_range(0, 4);
         ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6 * ((pt == 0) ? 1 : pt) + 5 * gt) : 0;
         run_checked($sformatf("rand%0d", i), dir, pt, gt, ab, 0, 1'b1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
